// File: rtl/fpu_issue_arb.sv
// rtl/fpu_issue_arb.sv - two-requester round-robin issue arbiter for a fixed-latency FPU
// Responses return in acceptance order through a LATENCY+1 deep tracking shift register.
module fpu_issue_arb #(
  parameter int LATENCY = 1,
  parameter int TAG_W   = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [31:0]      req0_op_a_i,
  input  logic [31:0]      req0_op_b_i,
  input  logic [1:0]       req0_op_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [31:0]      req1_op_a_i,
  input  logic [31:0]      req1_op_b_i,
  input  logic [1:0]       req1_op_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic [31:0]      op_a_o,
  output logic [31:0]      op_b_o,
  output logic [1:0]       fpu_op_o,
  output logic             alu_fpu_en_o,
  input  logic [31:0]      fpu_data_i,
  output logic             rsp0_valid_o,
  output logic             rsp1_valid_o,
  output logic [31:0]      rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_err_o,
  output logic             busy_o
);
  localparam int D = LATENCY + 1;

  logic             ptr_q, ptr_d;
  logic             gnt0, gnt1, acc, illegal;
  logic [31:0]      sel_a, sel_b;
  logic [1:0]       sel_op;
  logic [TAG_W-1:0] sel_tag;

  logic [31:0]      op_a_q, op_b_q;
  logic [1:0]       fpu_op_q;
  logic             en_q;
  logic [D-1:0]     trk_v_q, trk_id_q, trk_err_q;
  logic [TAG_W-1:0] trk_tag_q [D];
  logic             rsp0_q, rsp1_q, rsp_err_q;
  logic [31:0]      rsp_data_q;
  logic [TAG_W-1:0] rsp_tag_q;

  // ptr_q = 1 means requester 1 wins a tie.
  always_comb begin
    gnt0    = rst_ni & req0_valid_i & (~req1_valid_i | ~ptr_q);
    gnt1    = rst_ni & req1_valid_i & (~req0_valid_i | ptr_q);
    acc     = gnt0 | gnt1;
    sel_a   = gnt1 ? req1_op_a_i : req0_op_a_i;
    sel_b   = gnt1 ? req1_op_b_i : req0_op_b_i;
    sel_op  = gnt1 ? req1_op_i   : req0_op_i;
    sel_tag = gnt1 ? req1_tag_i  : req0_tag_i;
    illegal = sel_op[1];
    ptr_d   = ptr_q;
    if (gnt0)      ptr_d = 1'b1;
    else if (gnt1) ptr_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q      <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      fpu_op_q   <= '0;
      en_q       <= 1'b0;
      trk_v_q    <= '0;
      trk_id_q   <= '0;
      trk_err_q  <= '0;
      for (int i = 0; i < D; i++) trk_tag_q[i] <= '0;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      en_q  <= acc & ~illegal;
      if (acc && !illegal) begin
        op_a_q   <= sel_a;
        op_b_q   <= sel_b;
        fpu_op_q <= sel_op;
      end
      trk_v_q      <= {trk_v_q[D-2:0], acc};
      trk_id_q     <= {trk_id_q[D-2:0], gnt1};
      trk_err_q    <= {trk_err_q[D-2:0], illegal};
      trk_tag_q[0] <= sel_tag;
      for (int i = 1; i < D; i++) trk_tag_q[i] <= trk_tag_q[i-1];
      // The tail stage lines up with the cycle in which fpu_data_i is valid.
      rsp0_q <= trk_v_q[D-1] & ~trk_id_q[D-1];
      rsp1_q <= trk_v_q[D-1] & trk_id_q[D-1];
      if (trk_v_q[D-1]) begin
        rsp_data_q <= trk_err_q[D-1] ? 32'd0 : fpu_data_i;
        rsp_tag_q  <= trk_tag_q[D-1];
        rsp_err_q  <= trk_err_q[D-1];
      end
    end
  end

  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;
  assign op_a_o       = op_a_q;
  assign op_b_o       = op_b_q;
  assign fpu_op_o     = fpu_op_q;
  assign alu_fpu_en_o = en_q;
  assign rsp0_valid_o = rsp0_q;
  assign rsp1_valid_o = rsp1_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_tag_o    = rsp_tag_q;
  assign rsp_err_o    = rsp_err_q;
  assign busy_o       = (|trk_v_q) | rsp0_q | rsp1_q;

endmodule

// File: tb/tb_fpu_issue_arb.sv
// tb/tb_fpu_issue_arb.sv - bench for fpu_issue_arb at LATENCY 1 and 3 driven in parallel
module tb_fpu_issue_arb;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, v0, v1;
  logic [1:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic [3:0]  t0, t1;

  logic [1:0]  rdy0, rdy1, en, rv0, rv1, rerr, busy;
  logic [31:0] opa [2];
  logic [31:0] opb [2];
  logic [31:0] rdata [2];
  logic [31:0] fdat [2];
  logic [1:0]  fop [2];
  logic [3:0]  rtag [2];

  fpu_issue_arb #(.LATENCY(1), .TAG_W(4)) u0 (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(v0), .req0_ready_o(rdy0[0]), .req0_op_a_i(a0), .req0_op_b_i(b0),
    .req0_op_i(op0), .req0_tag_i(t0),
    .req1_valid_i(v1), .req1_ready_o(rdy1[0]), .req1_op_a_i(a1), .req1_op_b_i(b1),
    .req1_op_i(op1), .req1_tag_i(t1),
    .op_a_o(opa[0]), .op_b_o(opb[0]), .fpu_op_o(fop[0]), .alu_fpu_en_o(en[0]),
    .fpu_data_i(fdat[0]), .rsp0_valid_o(rv0[0]), .rsp1_valid_o(rv1[0]),
    .rsp_data_o(rdata[0]), .rsp_tag_o(rtag[0]), .rsp_err_o(rerr[0]), .busy_o(busy[0])
  );

  fpu_issue_arb #(.LATENCY(3), .TAG_W(4)) u1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(v0), .req0_ready_o(rdy0[1]), .req0_op_a_i(a0), .req0_op_b_i(b0),
    .req0_op_i(op0), .req0_tag_i(t0),
    .req1_valid_i(v1), .req1_ready_o(rdy1[1]), .req1_op_a_i(a1), .req1_op_b_i(b1),
    .req1_op_i(op1), .req1_tag_i(t1),
    .op_a_o(opa[1]), .op_b_o(opb[1]), .fpu_op_o(fop[1]), .alu_fpu_en_o(en[1]),
    .fpu_data_i(fdat[1]), .rsp0_valid_o(rv0[1]), .rsp1_valid_o(rv1[1]),
    .rsp_data_o(rdata[1]), .rsp_tag_o(rtag[1]), .rsp_err_o(rerr[1]), .busy_o(busy[1])
  );

  // Single-precision helpers for normal numbers and zero.
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] b;
    if (x[30:0] == 31'd0) b = {x[31], 63'd0};
    else b = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] b;
    logic [10:0] e;
    b = $realtobits(r);
    if (b[62:0] == 63'd0) return {b[63], 31'd0};
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  function automatic logic [31:0] fpres(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    return (op == 2'b00) ? r2sp(sp2r(a) + sp2r(b)) : r2sp(sp2r(a) - sp2r(b));
  endfunction

  // FPU stand-in: result presented LATENCY cycles after the enable pulse.
  logic [31:0] fq0 [4];
  logic [31:0] fq1 [4];
  always @(posedge clk) begin
    fq0[0] <= en[0] ? fpres(opa[0], opb[0], fop[0]) : 32'hDEADBEEF;
    fq1[0] <= en[1] ? fpres(opa[1], opb[1], fop[1]) : 32'hDEADBEEF;
    for (int i = 1; i < 4; i++) begin
      fq0[i] <= fq0[i-1];
      fq1[i] <= fq1[i-1];
    end
  end
  assign fdat[0] = fq0[0];
  assign fdat[1] = fq1[2];

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h want %h (t=%0t)", nm, d, act, exp, $time);
    end
  endtask

  // Model: a log of accepted ops; each DUT consumes it at its own latency.
  typedef struct {
    int          acc;
    bit          id;
    logic [3:0]  tag;
    bit          err;
    logic [31:0] data;
  } ent_t;
  ent_t log_q[$];
  int   hd [2];
  int   lat [2] = '{1, 3};
  int   cyc = 0;
  bit   chk_on = 0;
  bit   mptr = 0;
  bit   ex_en = 0;
  logic [31:0] ex_a = 0, ex_b = 0;
  logic [1:0]  ex_op = 0;
  logic [31:0] ex_rdata [2];
  logic [3:0]  ex_rtag [2];
  bit          ex_rerr [2];
  int          cnt0 [2], cnt1 [2], ecnt [2];

  function automatic bit [1:0] exp_grant(input logic r, input logic q0, input logic q1, input bit p);
    if (!r) return 2'b00;
    if (q0 && !q1) return 2'b01;
    if (q1 && !q0) return 2'b10;
    if (q0 && q1) return p ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    bit [1:0] g;
    ent_t e;
    if (!rst_n) begin
      chk_on = 1;
      mptr = 0; ex_en = 0; ex_a = 0; ex_b = 0; ex_op = 0;
      for (int d = 0; d < 2; d++) begin
        hd[d] = log_q.size(); ex_rdata[d] = 0; ex_rtag[d] = 0; ex_rerr[d] = 0;
      end
    end else begin
      g = exp_grant(rst_n, v0, v1, mptr);
      ex_en = 0;
      if (g != 2'b00) begin
        e.acc = cyc;
        e.id  = g[1];
        e.tag = g[1] ? t1 : t0;
        e.err = g[1] ? op1[1] : op0[1];
        e.data = e.err ? 32'd0 : (g[1] ? fpres(a1, b1, op1) : fpres(a0, b0, op0));
        log_q.push_back(e);
        if (!e.err) begin
          ex_en = 1;
          ex_a = g[1] ? a1 : a0; ex_b = g[1] ? b1 : b0; ex_op = g[1] ? op1 : op0;
        end
        mptr = ~g[1];
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit [1:0] g;
    bit due;
    if (chk_on) begin
      g = exp_grant(rst_n, v0, v1, mptr);
      for (int d = 0; d < 2; d++) begin
        chk("ready0", d, rdy0[d], g[0]);
        chk("ready1", d, rdy1[d], g[1]);
        chk("fpu_en", d, en[d], ex_en);
        chk("op_a", d, opa[d], ex_a);
        chk("op_b", d, opb[d], ex_b);
        chk("fpu_op", d, fop[d], ex_op);
        chk("busy", d, busy[d], hd[d] < log_q.size());
        due = (hd[d] < log_q.size()) && (log_q[hd[d]].acc + lat[d] + 2 == cyc);
        if (due) begin
          ex_rdata[d] = log_q[hd[d]].data;
          ex_rtag[d]  = log_q[hd[d]].tag;
          ex_rerr[d]  = log_q[hd[d]].err;
        end
        chk("rsp0_valid", d, rv0[d], due && !log_q[hd[d]].id);
        chk("rsp1_valid", d, rv1[d], due && log_q[hd[d]].id);
        chk("rsp_data", d, rdata[d], ex_rdata[d]);
        chk("rsp_tag", d, rtag[d], ex_rtag[d]);
        chk("rsp_err", d, rerr[d], ex_rerr[d]);
        if (due) hd[d]++;
        if (rv0[d] === 1'b1) cnt0[d]++;
        if (rv1[d] === 1'b1) cnt1[d]++;
        if (en[d] === 1'b1) ecnt[d]++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int s0 [2], s1 [2], se [2];
  task automatic snap;
    for (int d = 0; d < 2; d++) begin
      s0[d] = cnt0[d]; s1[d] = cnt1[d]; se[d] = ecnt[d];
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      cnt0[d] = 0; cnt1[d] = 0; ecnt[d] = 0; hd[d] = 0;
      ex_rdata[d] = 0; ex_rtag[d] = 0; ex_rerr[d] = 0;
    end
    rst_n = 0; v0 = 0; v1 = 0; op0 = 0; op1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0; t0 = 0; t1 = 0;
    chk("fp_model", 0, fpres(32'h3F800000, 32'h40000000, 2'b00), 32'h40400000);
    chk("fp_model_sub", 0, fpres(32'h40400000, 32'h3F800000, 2'b01), 32'h40000000);
    tick; tick;
    rst_n = 1;
    tick;

    // Single add from requester 0.
    snap;
    v0 = 1; op0 = 2'b00; a0 = 32'h3F800000; b0 = 32'h40000000; t0 = 4'd3;
    tick;
    v0 = 0;
    repeat (6) tick;
    for (int d = 0; d < 2; d++) begin
      chk("r35_count", d, cnt0[d] - s0[d], 1);
      chk("r35_data", d, rdata[d], 32'h40400000);
      chk("r35_tag", d, rtag[d], 3);
      chk("r35_err", d, rerr[d], 0);
    end

    // Contention from reset: grants alternate 0,1,0,1.
    rst_n = 0;
    tick;
    rst_n = 1;
    snap;
    for (int k = 0; k < 4; k++) begin
      v0 = 1; op0 = 2'b00; a0 = 32'h3F800000; b0 = 32'h3F800000; t0 = 4'(k);
      v1 = 1; op1 = 2'b01; a1 = 32'h40400000; b1 = 32'h3F800000; t1 = 4'(8 + k);
      @(negedge clk);
      chk("r36_grant0", 0, rdy0[0], (k % 2) == 0);
      chk("r36_grant1", 1, rdy1[1], (k % 2) == 1);
      tick;
    end
    v0 = 0; v1 = 0;
    repeat (6) tick;
    for (int d = 0; d < 2; d++) begin
      chk("r36_rsp0_count", d, cnt0[d] - s0[d], 2);
      chk("r36_rsp1_count", d, cnt1[d] - s1[d], 2);
      chk("r36_last_tag", d, rtag[d], 11);
      chk("r36_last_data", d, rdata[d], 32'h40000000);
    end

    // Illegal op from requester 1.
    snap;
    v1 = 1; op1 = 2'b10; a1 = 32'h12345678; b1 = 32'h9ABCDEF0; t1 = 4'd7;
    tick;
    v1 = 0;
    repeat (6) tick;
    for (int d = 0; d < 2; d++) begin
      chk("r37_no_en", d, ecnt[d] - se[d], 0);
      chk("r37_count", d, cnt1[d] - s1[d], 1);
      chk("r37_data", d, rdata[d], 0);
      chk("r37_err", d, rerr[d], 1);
      chk("r37_tag", d, rtag[d], 7);
    end

    // Reset with two ops in flight.
    snap;
    v0 = 1; op0 = 2'b00; a0 = 32'h40000000; b0 = 32'h40000000; t0 = 4'd5;
    tick;
    v0 = 0; v1 = 1; op1 = 2'b01; a1 = 32'h40400000; b1 = 32'h40000000; t1 = 4'd6;
    tick;
    v1 = 0; rst_n = 0;
    tick;
    rst_n = 1;
    repeat (8) tick;
    for (int d = 0; d < 2; d++) begin
      chk("r38_no_rsp", d, (cnt0[d] - s0[d]) + (cnt1[d] - s1[d]), 0);
      chk("r38_busy", d, busy[d], 0);
    end
    v0 = 1; v1 = 1; op0 = 2'b00; op1 = 2'b00; t0 = 4'd1; t1 = 4'd2;
    @(negedge clk);
    chk("r38_ptr_rdy0", 0, rdy0[0], 1);
    chk("r38_ptr_rdy1", 1, rdy1[1], 0);
    tick;
    v0 = 0; v1 = 0;
    repeat (6) tick;

    // Continuous stream of 8 ops from requester 1.
    snap;
    for (int k = 0; k < 8; k++) begin
      v1 = 1; op1 = 2'(k % 2); a1 = 32'h40000000 | (32'(k) << 20); b1 = 32'h3F800000;
      t1 = 4'(k);
      tick;
    end
    v1 = 0;
    repeat (10) tick;
    for (int d = 0; d < 2; d++) begin
      chk("r39_count", d, cnt1[d] - s1[d], 8);
      chk("r39_last_tag", d, rtag[d], 7);
      chk("r39_idle", d, busy[d], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpu_issue_arb.md
FPU_ISSUE_ARB -- requirements
Module: fpu_issue_arb

Interface
REQ-001 Parameter LATENCY, default 1: cycles from alu_fpu_en_o high to a valid fpu_data_i; legal range 1..4.
REQ-002 Parameter TAG_W, default 4: width of the requester transaction tag.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset; synchronous and active-low.
REQ-005 req0_valid_i / req1_valid_i  input  1 each  requester n presents an operation.
REQ-006 req0_ready_o / req1_ready_o  output  1 each  requester n's operation is accepted this cycle.
REQ-007 reqN_op_a_i, reqN_op_b_i  input  32 each  IEEE-754 single-precision operands for requester N.
REQ-008 reqN_op_i  input  2  operation code: 00 = add, 01 = sub, 1x = illegal.
REQ-009 reqN_tag_i  input  TAG_W  opaque tag, returned with the response.
REQ-010 op_a_o, op_b_o  output  32 each  operands driven to the FPU datapath.
REQ-011 fpu_op_o  output  2  operation code driven to the FPU datapath.
REQ-012 alu_fpu_en_o  output  1  FPU datapath enable; one-cycle pulse per issued operation.
REQ-013 fpu_data_i  input  32  FPU result, valid LATENCY cycles after alu_fpu_en_o.
REQ-014 rspN_valid_o  output  1 each  one-cycle response pulse to requester N; no backpressure.
REQ-015 rsp_data_o  output  32  result data, shared by both requesters.
REQ-016 rsp_tag_o  output  TAG_W  tag of the returned operation.
REQ-017 rsp_err_o  output  1  illegal-opcode flag.
REQ-018 busy_o  output  1  at least one operation is in flight.

Function
REQ-019 Handshake: an operation is accepted in cycle C when reqN_valid_i and reqN_ready_o are both high in C.
REQ-020 The block shall grant at most one requester per cycle and shall never deassert ready to stall; ready_o shall depend only on the valid inputs and the priority pointer.
REQ-021 Arbitration is round-robin over a 1-bit priority pointer:
- Only one valid: that requester is granted.
- Both valid: the requester indicated by the pointer is granted.
- After any grant, the pointer shall point to the requester that was not granted.
REQ-022 For a legal op accepted in C, at C+1 op_a_o, op_b_o and fpu_op_o shall hold the accepted values and alu_fpu_en_o shall be 1; otherwise alu_fpu_en_o shall be 0.
REQ-023 While alu_fpu_en_o is 0, op_a_o, op_b_o and fpu_op_o shall hold their last values.
REQ-024 Every accepted op (legal or illegal) enters a (LATENCY+1)-deep tracking shift register holding valid, requester id, tag and err.
REQ-025 Response timing for an op accepted in C: at C+LATENCY+2, rsp_valid_o of its requester shall pulse, with rsp_tag_o = its tag.
REQ-026 Response data: rsp_data_o shall be fpu_data_i registered at C+LATENCY+1 and rsp_err_o = 0; for an illegal op, rsp_data_o = 0 and rsp_err_o = 1.
REQ-027 An illegal op shall never assert alu_fpu_en_o but shall still return a response in its slot.
REQ-028 Responses shall return in acceptance order; back-to-back acceptances shall give back-to-back responses with no gaps or collisions.
REQ-029 At most one rspN_valid_o shall be high in any cycle.
REQ-030 When no response is due, rsp_data_o, rsp_tag_o and rsp_err_o shall hold their last values.
REQ-031 busy_o = OR of the tracking valids and the response-stage valid.

Reset
REQ-032 When rst_ni is sampled low: all tracking valids shall clear, the priority pointer shall be set to requester 0, and all outputs shall be 0 on the following cycle.
REQ-033 Operations in flight at reset shall be discarded; no response for them shall appear after reset.
REQ-034 While rst_ni is low, both ready outputs shall be 0 and nothing shall be accepted.

Verification
REQ-035 LATENCY=1, requester 0 only, op=00, a=0x3F800000, b=0x40000000, tag=3 -> alu_fpu_en_o at C+1; rsp0_valid_o at C+3 with rsp_data_o = model FPU result 0x40400000, rsp_tag_o=3, rsp_err_o=0.
REQ-036 Both valid for 4 consecutive cycles from reset -> grants 0,1,0,1; responses on rsp0, rsp1, rsp0, rsp1 in 4 consecutive cycles with matching tags.
REQ-037 Requester 1 op=10, tag=7 -> alu_fpu_en_o stays 0; rsp1_valid_o at C+LATENCY+2 with rsp_data_o=0, rsp_err_o=1, rsp_tag_o=7.
REQ-038 Accept 2 ops, drop rst_ni for 1 cycle before either response -> no rsp*_valid_o thereafter; busy_o=0 after reset; pointer favours requester 0.
REQ-039 LATENCY=3, continuous requester-1 stream of 8 ops -> exactly 8 responses, in order, each at acceptance+5; busy_o high throughout and 0 one cycle after the last response.
